// File: rtl/mem_vio_detect.sv
// Memory-order violation detector.
// Tracks loads that have executed with an address and checks each issuing
// store against them. A younger load with an overlapping byte mask in the
// same 8-byte granule has read stale data. The oldest such load is reported
// one cycle later so that the pipeline can replay from it and the dependence
// predictor can learn the store/load pair.
`ifndef STORE_ISSUE_WIDTH
`define STORE_ISSUE_WIDTH 2
`endif
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 10
`endif

module mem_vio_detect #(
    parameter int ENTRIES     = 16,
    parameter int LOAD_WIDTH  = 2,
    parameter int STORE_WIDTH = `STORE_ISSUE_WIDTH,
    parameter int FOLDPC_W    = `MEMDEP_FOLDPC_WIDTH,
    parameter int GRAN_W      = 37,
    // ROB index bits excluding the wrap (flipped) bit
    parameter int ROB_IDX_W   = 6
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LOAD_WIDTH-1:0]                 i_load_vld,
    input  logic [LOAD_WIDTH-1:0][ROB_IDX_W:0]    i_load_robIdx,
    input  logic [LOAD_WIDTH-1:0][FOLDPC_W-1:0]   i_load_foldpc,
    input  logic [LOAD_WIDTH-1:0][GRAN_W-1:0]     i_load_gran,
    input  logic [LOAD_WIDTH-1:0][7:0]            i_load_mask,
    output logic                                  o_load_rdy,
    input  logic [STORE_WIDTH-1:0]                i_store_vld,
    input  logic [STORE_WIDTH-1:0][ROB_IDX_W:0]   i_store_robIdx,
    input  logic [STORE_WIDTH-1:0][FOLDPC_W-1:0]  i_store_foldpc,
    input  logic [STORE_WIDTH-1:0][GRAN_W-1:0]    i_store_gran,
    input  logic [STORE_WIDTH-1:0][7:0]           i_store_mask,
    input  logic                                  i_commit_vld,
    input  logic [ROB_IDX_W:0]                    i_commit_robIdx,
    input  logic                                  i_squash,
    input  logic [ROB_IDX_W:0]                    i_squash_robIdx,
    output logic                                  o_violation,
    output logic [FOLDPC_W-1:0]                   o_vio_store_foldpc,
    output logic [FOLDPC_W-1:0]                   o_vio_load_foldpc,
    output logic [ROB_IDX_W:0]                    o_vio_load_robIdx
);

    localparam int ROB_W  = ROB_IDX_W + 1;
    localparam int CNT_W  = $clog2(ENTRIES + 1);
    localparam int EIDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // a older than b, with the wrap bit flipping the index comparison
    function automatic logic is_older(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
        if (a[ROB_W-1] == b[ROB_W-1]) return a[ROB_W-2:0] < b[ROB_W-2:0];
        else                          return a[ROB_W-2:0] > b[ROB_W-2:0];
    endfunction

    // Entry storage
    logic [ENTRIES-1:0]  vld_q, vld_d;
    logic [ROB_W-1:0]    rob_q    [ENTRIES];
    logic [ROB_W-1:0]    rob_d    [ENTRIES];
    logic [FOLDPC_W-1:0] fpc_q    [ENTRIES];
    logic [FOLDPC_W-1:0] fpc_d    [ENTRIES];
    logic [GRAN_W-1:0]   gran_q   [ENTRIES];
    logic [GRAN_W-1:0]   gran_d   [ENTRIES];
    logic [7:0]          mask_q   [ENTRIES];
    logic [7:0]          mask_d   [ENTRIES];

    // Report state
    logic                pending_q;
    logic                vio_q;
    logic [FOLDPC_W-1:0] vio_sfpc_q;
    logic [FOLDPC_W-1:0] vio_lfpc_q;
    logic [ROB_W-1:0]    vio_rob_q;

    logic [CNT_W-1:0]    free_cnt;
    logic                load_rdy;
    logic [LOAD_WIDTH-1:0] load_wr;
    logic [EIDX_W-1:0]   alloc_idx [LOAD_WIDTH];

    logic                best_found;
    logic [ROB_W-1:0]    best_rob;
    logic [FOLDPC_W-1:0] best_lfpc;
    logic [FOLDPC_W-1:0] best_sfpc;
    logic                report;

    // Free-entry count from registered state only; frees this cycle do not help
    always_comb begin
        free_cnt = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (!vld_q[e]) free_cnt = free_cnt + CNT_W'(1);
        end
    end

    assign load_rdy   = (free_cnt >= CNT_W'(LOAD_WIDTH));
    assign load_wr    = load_rdy ? i_load_vld : '0;
    assign o_load_rdy = load_rdy;

    // Load port k claims the k-th lowest-indexed free entry
    always_comb begin
        int cnt;
        cnt = 0;
        for (int k = 0; k < LOAD_WIDTH; k++) alloc_idx[k] = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (!vld_q[e]) begin
                for (int k = 0; k < LOAD_WIDTH; k++) begin
                    if (cnt == k) alloc_idx[k] = EIDX_W'(e);
                end
                cnt = cnt + 1;
            end
        end
    end

    // Find the oldest younger overlapping load over table entries and
    // same-cycle loads; stores scanned from port 0 so ties keep the lowest port
    always_comb begin
        best_found = 1'b0;
        best_rob   = '0;
        best_lfpc  = '0;
        best_sfpc  = '0;
        for (int s = 0; s < STORE_WIDTH; s++) begin
            if (i_store_vld[s]) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    if (vld_q[e] && is_older(i_store_robIdx[s], rob_q[e]) &&
                        (gran_q[e] == i_store_gran[s]) && ((mask_q[e] & i_store_mask[s]) != 8'h00)) begin
                        if (!best_found || is_older(rob_q[e], best_rob)) begin
                            best_found = 1'b1;
                            best_rob   = rob_q[e];
                            best_lfpc  = fpc_q[e];
                            best_sfpc  = i_store_foldpc[s];
                        end
                    end
                end
                for (int k = 0; k < LOAD_WIDTH; k++) begin
                    if (load_wr[k] && is_older(i_store_robIdx[s], i_load_robIdx[k]) &&
                        (i_load_gran[k] == i_store_gran[s]) && ((i_load_mask[k] & i_store_mask[s]) != 8'h00)) begin
                        if (!best_found || is_older(i_load_robIdx[k], best_rob)) begin
                            best_found = 1'b1;
                            best_rob   = i_load_robIdx[k];
                            best_lfpc  = i_load_foldpc[k];
                            best_sfpc  = i_store_foldpc[s];
                        end
                    end
                end
            end
        end
    end

    // A squash cycle never reports, and an outstanding report blocks new ones
    assign report = best_found && !pending_q && !i_squash;

    // Entry next state: commit frees old entries, then allocation, then squash
    // (squash also removes entries allocated this cycle)
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            vld_d[e]  = vld_q[e];
            rob_d[e]  = rob_q[e];
            fpc_d[e]  = fpc_q[e];
            gran_d[e] = gran_q[e];
            mask_d[e] = mask_q[e];
            if (i_commit_vld && vld_q[e] &&
                (is_older(rob_q[e], i_commit_robIdx) || (rob_q[e] == i_commit_robIdx)))
                vld_d[e] = 1'b0;
            for (int k = 0; k < LOAD_WIDTH; k++) begin
                if (load_wr[k] && (alloc_idx[k] == EIDX_W'(e))) begin
                    vld_d[e]  = 1'b1;
                    rob_d[e]  = i_load_robIdx[k];
                    fpc_d[e]  = i_load_foldpc[k];
                    gran_d[e] = i_load_gran[k];
                    mask_d[e] = i_load_mask[k];
                end
            end
            if (i_squash && vld_d[e] && !is_older(rob_d[e], i_squash_robIdx))
                vld_d[e] = 1'b0;
        end
    end

    // Entry valid bits and report registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            pending_q  <= 1'b0;
            vio_q      <= 1'b0;
            vio_sfpc_q <= '0;
            vio_lfpc_q <= '0;
            vio_rob_q  <= '0;
        end else begin
            vld_q <= vld_d;
            vio_q <= report;
            if (report) begin
                vio_sfpc_q <= best_sfpc;
                vio_lfpc_q <= best_lfpc;
                vio_rob_q  <= best_rob;
            end
            if (i_squash)    pending_q <= 1'b0;
            else if (report) pending_q <= 1'b1;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENTRIES; e++) begin
            rob_q[e]  <= rob_d[e];
            fpc_q[e]  <= fpc_d[e];
            gran_q[e] <= gran_d[e];
            mask_q[e] <= mask_d[e];
        end
    end

    assign o_violation        = vio_q;
    assign o_vio_store_foldpc = vio_sfpc_q;
    assign o_vio_load_foldpc  = vio_lfpc_q;
    assign o_vio_load_robIdx  = vio_rob_q;

endmodule

// File: tb/tb_mem_vio_detect.sv
// Directed bench for mem_vio_detect with hand-computed expectations.
module tb_mem_vio_detect;
  localparam int LW = 2;
  localparam int SW = 2;
  localparam int FW = 10;
  localparam int GW = 37;
  localparam int RW = 7;

  logic                      clk;
  logic                      rst;
  logic [LW-1:0]             i_load_vld;
  logic [LW-1:0][RW-1:0]     i_load_robIdx;
  logic [LW-1:0][FW-1:0]     i_load_foldpc;
  logic [LW-1:0][GW-1:0]     i_load_gran;
  logic [LW-1:0][7:0]        i_load_mask;
  logic                      o_load_rdy;
  logic [SW-1:0]             i_store_vld;
  logic [SW-1:0][RW-1:0]     i_store_robIdx;
  logic [SW-1:0][FW-1:0]     i_store_foldpc;
  logic [SW-1:0][GW-1:0]     i_store_gran;
  logic [SW-1:0][7:0]        i_store_mask;
  logic                      i_commit_vld;
  logic [RW-1:0]             i_commit_robIdx;
  logic                      i_squash;
  logic [RW-1:0]             i_squash_robIdx;
  logic                      o_violation;
  logic [FW-1:0]             o_vio_store_foldpc;
  logic [FW-1:0]             o_vio_load_foldpc;
  logic [RW-1:0]             o_vio_load_robIdx;

  int checks_total;
  int checks_passed;

  mem_vio_detect dut (
    .clk                (clk),
    .rst                (rst),
    .i_load_vld         (i_load_vld),
    .i_load_robIdx      (i_load_robIdx),
    .i_load_foldpc      (i_load_foldpc),
    .i_load_gran        (i_load_gran),
    .i_load_mask        (i_load_mask),
    .o_load_rdy         (o_load_rdy),
    .i_store_vld        (i_store_vld),
    .i_store_robIdx     (i_store_robIdx),
    .i_store_foldpc     (i_store_foldpc),
    .i_store_gran       (i_store_gran),
    .i_store_mask       (i_store_mask),
    .i_commit_vld       (i_commit_vld),
    .i_commit_robIdx    (i_commit_robIdx),
    .i_squash           (i_squash),
    .i_squash_robIdx    (i_squash_robIdx),
    .o_violation        (o_violation),
    .o_vio_store_foldpc (o_vio_store_foldpc),
    .o_vio_load_foldpc  (o_vio_load_foldpc),
    .o_vio_load_robIdx  (o_vio_load_robIdx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total = checks_total + 1;
    if (got === exp) checks_passed = checks_passed + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic idle();
    i_load_vld = '0; i_load_robIdx = '0; i_load_foldpc = '0; i_load_gran = '0; i_load_mask = '0;
    i_store_vld = '0; i_store_robIdx = '0; i_store_foldpc = '0; i_store_gran = '0; i_store_mask = '0;
    i_commit_vld = 1'b0; i_commit_robIdx = '0;
    i_squash = 1'b0; i_squash_robIdx = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input int p, input logic [RW-1:0] rob, input logic [FW-1:0] fpc,
                          input logic [GW-1:0] gran, input logic [7:0] mask);
    i_load_vld[p] = 1'b1; i_load_robIdx[p] = rob; i_load_foldpc[p] = fpc;
    i_load_gran[p] = gran; i_load_mask[p] = mask;
  endtask

  task automatic set_store(input int p, input logic [RW-1:0] rob, input logic [FW-1:0] fpc,
                           input logic [GW-1:0] gran, input logic [7:0] mask);
    i_store_vld[p] = 1'b1; i_store_robIdx[p] = rob; i_store_foldpc[p] = fpc;
    i_store_gran[p] = gran; i_store_mask[p] = mask;
  endtask

  task automatic squash_all();
    idle(); i_squash = 1'b1; i_squash_robIdx = 7'd0; tick(); idle();
  endtask

  // fill 15 of 16 entries with robs {0,1}..{0,15}
  task automatic fill15();
    for (int i = 0; i < 7; i++) begin
      idle();
      set_load(0, RW'(2*i+1), 10'h001, 37'h400, 8'h01);
      set_load(1, RW'(2*i+2), 10'h002, 37'h400, 8'h01);
      tick();
    end
    idle();
    check("rdy_14_used", o_load_rdy, 1);
    set_load(0, 7'd15, 10'h003, 37'h400, 8'h01);
    tick(); idle();
    check("rdy_15_used", o_load_rdy, 0);
  endtask

  initial begin
    checks_total = 0;
    checks_passed = 0;
    idle();
    rst = 1'b1;
    repeat (2) tick();
    check("rst_violation", o_violation, 0);
    check("rst_load_rdy", o_load_rdy, 1);
    check("rst_sfpc", o_vio_store_foldpc, 0);
    check("rst_lrob", o_vio_load_robIdx, 0);
    rst = 1'b0;
    tick();

    // basic violation
    set_load(0, 7'd10, 10'h011, 37'h100, 8'h0F); tick(); idle();
    check("basic_no_early", o_violation, 0);
    set_store(0, 7'd5, 10'h02A, 37'h100, 8'h01); tick(); idle();
    check("basic_vio", o_violation, 1);
    check("basic_lrob", o_vio_load_robIdx, 10);
    check("basic_sfpc", o_vio_store_foldpc, 10'h02A);
    check("basic_lfpc", o_vio_load_foldpc, 10'h011);
    tick();
    check("basic_pulse_1cyc", o_violation, 0);
    check("basic_hold_sfpc", o_vio_store_foldpc, 10'h02A);
    squash_all();

    // no overlap, and load older than store
    set_load(0, 7'd10, 10'h011, 37'h100, 8'h0F); tick(); idle();
    set_store(0, 7'd5, 10'h02A, 37'h100, 8'hF0); tick(); idle();
    check("mask_disjoint", o_violation, 0);
    set_store(0, 7'd12, 10'h02A, 37'h100, 8'h01); tick(); idle();
    check("load_older", o_violation, 0);
    squash_all();

    // two loads, two stores: oldest load, lowest store port
    set_load(0, 7'd20, 10'h120, 37'h200, 8'hFF);
    set_load(1, 7'd15, 10'h115, 37'h200, 8'hFF);
    tick(); idle();
    set_store(0, 7'd3, 10'h031, 37'h200, 8'h01);
    set_store(1, 7'd4, 10'h032, 37'h200, 8'h01);
    tick(); idle();
    check("multi_vio", o_violation, 1);
    check("multi_lrob", o_vio_load_robIdx, 15);
    check("multi_sfpc", o_vio_store_foldpc, 10'h031);
    check("multi_lfpc", o_vio_load_foldpc, 10'h115);
    tick();
    check("multi_single_pulse", o_violation, 0);
    set_store(0, 7'd5, 10'h033, 37'h200, 8'h01); tick(); idle();
    check("pending_blocks", o_violation, 0);
    check("pending_hold_sfpc", o_vio_store_foldpc, 10'h031);
    squash_all();

    // same-cycle load and store
    set_load(1, 7'd30, 10'h066, 37'h700, 8'h80);
    set_store(1, 7'd25, 10'h055, 37'h700, 8'h80);
    tick(); idle();
    check("samecyc_vio", o_violation, 1);
    check("samecyc_lrob", o_vio_load_robIdx, 30);
    check("samecyc_lfpc", o_vio_load_foldpc, 10'h066);
    squash_all();

    // squash in the store cycle suppresses detection but keeps older load
    set_load(0, 7'd10, 10'h0AA, 37'h800, 8'h01); tick(); idle();
    set_store(0, 7'd5, 10'h0BB, 37'h800, 8'h01);
    i_squash = 1'b1; i_squash_robIdx = 7'd20;
    tick(); idle();
    check("squash_suppress", o_violation, 0);
    set_store(0, 7'd5, 10'h0BC, 37'h800, 8'h01); tick(); idle();
    check("after_squash_vio", o_violation, 1);
    check("after_squash_sfpc", o_vio_store_foldpc, 10'h0BC);
    squash_all();

    // wrap: store {0,62} older than load {1,1}
    set_load(0, 7'h41, 10'h141, 37'h300, 8'h01); tick(); idle();
    set_store(0, 7'd62, 10'h03E, 37'h300, 8'h01); tick(); idle();
    check("wrap_vio", o_violation, 1);
    check("wrap_lrob", o_vio_load_robIdx, 7'h41);
    i_squash = 1'b1; i_squash_robIdx = 7'h41; tick(); idle();
    set_load(0, 7'h41, 10'h141, 37'h300, 8'h01); tick(); idle();
    i_commit_vld = 1'b1; i_commit_robIdx = 7'h41; tick(); idle();
    set_store(0, 7'd62, 10'h03E, 37'h300, 8'h01); tick(); idle();
    check("wrap_committed", o_violation, 0);

    // capacity, ignored load while full, commit frees
    fill15();
    set_load(0, 7'd40, 10'h140, 37'h500, 8'h01); tick(); idle();
    i_commit_vld = 1'b1; i_commit_robIdx = 7'd15; tick(); idle();
    check("commit_frees_rdy", o_load_rdy, 1);
    set_store(0, 7'd35, 10'h035, 37'h500, 8'h01); tick(); idle();
    check("stalled_load_ignored", o_violation, 0);

    // capacity, squash from {0,0}
    fill15();
    squash_all();
    check("squash_frees_rdy", o_load_rdy, 1);

    // reset between match and report
    set_load(0, 7'd10, 10'h010, 37'h600, 8'h01); tick(); idle();
    set_store(0, 7'd5, 10'h005, 37'h600, 8'h01);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    idle();
    check("rst_mid_vio", o_violation, 0);
    rst = 1'b0;
    tick();
    check("rst_after_vio", o_violation, 0);
    check("rst_after_rdy", o_load_rdy, 1);
    check("rst_after_sfpc", o_vio_store_foldpc, 0);
    set_store(0, 7'd5, 10'h005, 37'h600, 8'h01); tick(); idle();
    check("rst_entries_gone", o_violation, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/mem_vio_detect.md
MEM_VIO_DETECT -- requirements
Module: memVioDetect

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning number of executed-load tracking entries.
REQ-002 SHALL have parameter LOAD_WIDTH, default 2, meaning load execute ports per cycle.
REQ-003 SHALL have parameter STORE_WIDTH, default `STORE_ISSUE_WIDTH, meaning store issue ports per cycle.
REQ-004 SHALL have parameter FOLDPC_W, default `MEMDEP_FOLDPC_WIDTH, meaning folded-PC width.
REQ-005 SHALL have parameter GRAN_W, default 37, meaning 8-byte address-granule width (PA[39:3]).
REQ-006 SHALL use exactly one clock; reset is asynchronous and active-high.
REQ-007 SHALL have ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_load_vld  in  LOAD_WIDTH  load executed with address this cycle
- i_load_robIdx  in  robIdx_t[LOAD_WIDTH]  load ROB index ({flipped, idx})
- i_load_foldpc  in  FOLDPC_W[LOAD_WIDTH]  load folded PC
- i_load_gran  in  GRAN_W[LOAD_WIDTH]  load address granule
- i_load_mask  in  8[LOAD_WIDTH]  load byte mask
- o_load_rdy  out  1  free entries >= LOAD_WIDTH
- i_store_vld  in  STORE_WIDTH  store issued with address this cycle
- i_store_robIdx  in  robIdx_t[STORE_WIDTH]  store ROB index
- i_store_foldpc  in  FOLDPC_W[STORE_WIDTH]  store folded PC
- i_store_gran  in  GRAN_W[STORE_WIDTH]  store granule
- i_store_mask  in  8[STORE_WIDTH]  store byte mask
- i_commit_vld  in  1  commit pointer update
- i_commit_robIdx  in  robIdx_t  youngest committed instruction
- i_squash  in  1  pipeline flush
- i_squash_robIdx  in  robIdx_t  oldest squashed instruction
- o_violation  out  1  one-cycle violation pulse (drives memDepPred i_violation)
- o_vio_store_foldpc  out  FOLDPC_W  violating store folded PC
- o_vio_load_foldpc  out  FOLDPC_W  violating load folded PC
- o_vio_load_robIdx  out  robIdx_t  load to re-execute from

Function
REQ-008 SHALL define "A older than B" as (A.flipped==B.flipped) ? A.idx<B.idx : A.idx>B.idx.
REQ-009 SHALL hold per entry: vld, robIdx, foldpc, gran, mask.
REQ-010 SHALL, when o_load_rdy=1, write each valid load port k into the k-th lowest-indexed free entry; loads presented while o_load_rdy=0 SHALL be ignored (caller stalls).
REQ-011 SHALL compute o_load_rdy from registered state only (free count >= LOAD_WIDTH), excluding same-cycle frees.
REQ-012 SHALL, on i_commit_vld, clear vld of every pre-existing entry whose robIdx is older than or equal to i_commit_robIdx; same-cycle allocations are unaffected.
REQ-013 SHALL, on i_squash, clear vld of every entry (including same-cycle allocations) whose robIdx is older-or-equal-younger, i.e. equal to or younger than i_squash_robIdx.
REQ-014 SHALL flag a match for store s and load L when L valid (table entry or same-cycle load port), L younger than s, gran equal, (mask_s & mask_L) != 0.
REQ-015 SHALL select, among all matches in a cycle, the oldest load; ties on that load SHALL pick the lowest store port.
REQ-016 SHALL register the result: o_violation=1 and payload valid exactly one cycle after the store-issue cycle; o_violation SHALL be 0 otherwise.
REQ-017 SHALL hold o_vio_* payload stable between reports.
REQ-018 SHALL set a pending flag when reporting; while pending, further matches SHALL NOT raise o_violation; i_squash SHALL clear pending.
REQ-019 SHALL suppress detection in any cycle with i_squash=1 (squash wins over same-cycle store issue).
REQ-020 SHALL treat commit, squash, allocation and detection in one cycle as: detection uses pre-update entries plus same-cycle loads, then updates apply.

Reset
REQ-021 SHALL, on rst, asynchronously clear all entry vld bits, pending, o_violation=0, o_vio_store_foldpc=0, o_vio_load_foldpc=0, o_vio_load_robIdx=0; o_load_rdy=1 after reset.
REQ-022 SHALL abandon any in-flight detection on rst asserted mid-operation; no o_violation pulse after rst deasserts without a new match.

Verification
REQ-023 Load rob{0,10} gran 0x100 mask 0x0F; next cycle store rob{0,5} gran 0x100 mask 0x01, foldpc 0x2A -> o_violation=1 next cycle, o_vio_load_robIdx={0,10}, o_vio_store_foldpc=0x2A.
REQ-024 Same as REQ-023 but store mask 0xF0 -> no violation; store rob{0,12} mask 0x01 -> no violation (load older).
REQ-025 Loads rob{0,20} and {0,15} matching two stores same cycle -> single pulse reporting {0,15}; second store issue before squash -> no pulse.
REQ-026 Wrap: store rob{0,62}, load rob{1,1} same granule/mask -> violation; commit {1,1} before store -> entry freed, no violation.
REQ-027 Fill ENTRIES-1 entries -> o_load_rdy=0; squash from {0,0} -> all freed, o_load_rdy=1 next cycle.
REQ-028 rst asserted mid-cycle between match and report -> o_violation stays 0, all entries invalid.
